// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: transfer-phase encoding and counter sizing,
// common to the arbiter, master port and slave port.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } bus_state_t;

    // Bits needed to hold any value 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Word storage behind the slave port: one write port, and a read port whose word is
// captured into the port's read shifter on the same clock edge that presents the address.
module slave_mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // Contents deliberately survive reset.
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: shifts in address and write data MSB first, streams read data
// MSB first with no backpressure, and supports fixed-length bursts with address wrap.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic address,
    input  logic data,
    input  logic valid,
    input  logic write_en,
    input  logic burst,
    output logic ready,
    output logic data_out,
    output logic valid_out
);

    localparam int CW = cnt_width((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
    localparam int WW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] BURST_LAST = WW'(BURST_LEN - 1);

    bus_state_t            r_state;
    logic                  r_ready;
    logic                  r_vout;
    logic                  r_wr;
    logic                  r_burst;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wsh;
    logic [DATA_WIDTH-1:0] r_rsh;
    logic [CW-1:0]         r_cnt;
    logic [WW-1:0]         r_wcnt;

    logic [ADDR_WIDTH-1:0] w_addr_shift;
    logic [DATA_WIDTH-1:0] w_wword;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_addr_last;
    logic                  w_is_wr;
    logic                  w_more;
    logic                  w_we;

    assign w_addr_shift = (r_addr << 1) | ADDR_WIDTH'(address);
    assign w_wword      = (r_wsh << 1) | DATA_WIDTH'(data);
    // r_cnt is 0 in IDLE, so a 1-bit address completes on the very first sample.
    assign w_addr_last  = ((r_state == IDLE) || (r_state == ADDR)) && (r_cnt == ADDR_LAST);
    assign w_is_wr      = (r_state == IDLE) ? write_en : r_wr;
    assign w_more       = r_burst && (r_wcnt != BURST_LAST);
    assign w_we         = (r_state == WDATA) && valid && (r_cnt == DATA_LAST);
    assign w_raddr      = (r_state == RDATA) ? (r_addr + ADDR_WIDTH'(1)) : w_addr_shift;

    slave_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .i_clk  (clk),
        .i_we   (w_we),
        .i_waddr(r_addr),
        .i_wdata(w_wword),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_vout  <= 1'b0;
            r_wr    <= 1'b0;
            r_burst <= 1'b0;
            r_addr  <= '0;
            r_wsh   <= '0;
            r_rsh   <= '0;
            r_cnt   <= '0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                IDLE, ADDR: begin
                    r_ready <= 1'b1;
                    if (valid) begin
                        if (r_state == IDLE) begin
                            r_wr    <= write_en;
                            r_burst <= burst;
                        end
                        r_addr <= w_addr_shift;
                        if (w_addr_last) begin
                            r_cnt  <= '0;
                            r_wcnt <= '0;
                            if (w_is_wr) begin
                                r_state <= WDATA;
                            end else begin
                                r_state <= RDATA;
                                r_ready <= 1'b0;
                                r_vout  <= 1'b1;
                                r_rsh   <= w_rdata;
                            end
                        end else begin
                            r_state <= ADDR;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end
                WDATA: begin
                    if (valid) begin
                        r_wsh <= w_wword;
                        if (r_cnt == DATA_LAST) begin
                            r_cnt <= '0;
                            if (w_more) begin
                                r_wcnt <= r_wcnt + WW'(1);
                                r_addr <= r_addr + ADDR_WIDTH'(1);
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                RDATA: begin
                    // The next burst word loads as the last bit of the current one leaves.
                    if (r_cnt == DATA_LAST) begin
                        r_cnt <= '0;
                        if (w_more) begin
                            r_wcnt <= r_wcnt + WW'(1);
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                            r_rsh  <= w_rdata;
                        end else begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_vout  <= 1'b0;
                            r_rsh   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_rsh <= r_rsh << 1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = r_ready;
    assign valid_out = r_vout;
    assign data_out  = r_rsh[DATA_WIDTH-1];

endmodule
